// File: rtl/adder_bist_pkg.sv
// Shared definitions for the 4-bit adder BIST controller: state encodings and vector/error widths.
package adder_bist_pkg;

    localparam int VEC_W    = 9;
    localparam int LAST_VEC = 511;
    localparam int ERR_W    = 10;
    localparam int SUM_W    = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/adder_bist_golden.sv
// Reference 4-bit adder: full 5-bit sum of A + B + C0, carry kept in the top bit.
module adder_bist_golden
    import adder_bist_pkg::*;
(
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             C0,
    output logic [SUM_W-1:0] sum
);

    assign sum = {1'b0, A} + {1'b0, B} + {4'b0000, C0};

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive BIST controller for a 4-bit adder: walks all 512 {C0,A,B} vectors and counts mismatches.
// Optional macro ADDER_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             C0,
    input  logic [3:0]       F,
    input  logic             C4,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec,
    output logic [1:0]       state_dbg
);

    // Control protocol: start is a one-cycle request accepted only when busy is low;
    // busy is high for the whole run, done stays high from run end until the next
    // accepted start or reset. Results are stable whenever done is high.

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(LAST_VEC);

    logic [1:0]       state;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic [SUM_W-1:0] golden_sum;
    logic             mismatch;
    logic             stop_now;
    logic [ERR_W-1:0] err_cnt_nxt;

    // Operands come straight from idx, so they hold the last vector in DONE.
    assign {C0, A, B} = idx;
    assign state_dbg  = state;

    adder_bist_golden u_golden (
        .A   (A),
        .B   (B),
        .C0  (C0),
        .sum (golden_sum)
    );

    assign mismatch    = ({C4, F} != golden_sum);
    assign err_cnt_nxt = mismatch ? err_cnt + 10'd1 : err_cnt;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        idx        <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_cnt <= err_cnt_nxt;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= idx;
                    end
                    if (idx == LAST_IDX || stop_now) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt_nxt == '0);
                    end else begin
                        state      <= ST_DRIVE;
                        idx        <= idx + 9'd1;
                        settle_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: behavioural adder with injectable faults, per-run result scoreboard.
module tb_adder_bist_ctrl;
    import adder_bist_pkg::*;

    localparam int S = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       A, B, F;
    logic             C0, C4;
    logic             busy, done, pass, fail_valid;
    logic [ERR_W-1:0] err_cnt;
    logic [VEC_W-1:0] fail_vec;
    logic [1:0]       state_dbg;
    logic [1:0]       fault_mode;

    logic [20:0] exp_q[$];
    int n_vec;
    int n_err;

    adder_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (A),
        .B          (B),
        .C0         (C0),
        .F          (F),
        .C4         (C4),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder under test: 0 = good, 1 = C4 stuck at 0, 2 = F[0] stuck at 0
    always_comb begin
        logic [4:0] s;
        s  = {1'b0, A} + {1'b0, B} + {4'b0000, C0};
        F  = s[3:0];
        C4 = s[4];
        if (fault_mode == 2'd1) C4 = 1'b0;
        if (fault_mode == 2'd2) F[0] = 1'b0;
    end

    // ---------------- driver helpers ----------------
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected {pass, fail_valid, fail_vec, err_cnt} and run length for a fault mode
    function automatic logic [20:0] model_run(input int fault, output int cyc);
        int         errs;
        logic       fv;
        logic [8:0] first;
        logic [8:0] v;
        logic [4:0] gold, obs;
        bit         stopped;
        errs = 0; fv = 1'b0; first = '0; stopped = 0;
        cyc = 512 * (S + 1);
        for (int i = 0; i < 512; i++) begin
            if (!stopped) begin
                v    = 9'(i);
                gold = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
                obs  = gold;
                if (fault == 1) obs[4] = 1'b0;
                if (fault == 2) obs[0] = 1'b0;
                if (obs != gold) begin
                    errs++;
                    if (!fv) begin
                        fv    = 1'b1;
                        first = v;
                    end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
                    stopped = 1;
                    cyc     = (i + 1) * (S + 1);
`endif
                end
            end
        end
        return {(errs == 0), fv, first, 10'(errs)};
    endfunction

    // One run: start, walk vectors, optional stray start or abort, then score results
    task automatic run_check(input int fault, input string name, input int mid_vec, input int abort_vec);
        int          cyc_exp, n;
        logic [20:0] exp, got;
        logic [8:0]  last_exp;
        exp = model_run(fault, cyc_exp);
        if (abort_vec < 0) exp_q.push_back(exp);
        fault_mode = 2'(fault);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({busy, done, pass, fail_valid, state_dbg} !== {1'b1, 1'b0, 1'b0, 1'b0, ST_DRIVE}
            || err_cnt !== '0 || fail_vec !== '0 || {C0, A, B} !== 9'd0) begin
            n_err++;
            $display("FAIL %s entry: busy=%b done=%b pass=%b fv=%b st=%0d err=%0d fvec=%0d vec=%0d, want busy=1 others 0 st=%0d",
                     name, busy, done, pass, fail_valid, state_dbg, err_cnt, fail_vec, {C0, A, B}, ST_DRIVE);
        end
        n = 0;
        while (done !== 1'b1 && n <= cyc_exp + 10) begin
            if (abort_vec >= 0 && n == abort_vec * (S + 1)) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                n_vec++;
                if ({A, B, C0, busy, done, pass, err_cnt, fail_valid, fail_vec} !== 32'd0 || state_dbg !== ST_IDLE) begin
                    n_err++;
                    $display("FAIL %s reset: outputs=%h st=%0d, want 0 st=%0d", name,
                             {A, B, C0, busy, done, pass, err_cnt, fail_valid, fail_vec}, state_dbg, ST_IDLE);
                end
                for (int k = 0; k < 5; k++) tick();
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s post_abort: done=%b busy=%b, want 0 0", name, done, busy);
                end
                return;
            end
            start = (mid_vec >= 0 && n == mid_vec * (S + 1));
            tick();
            start = 1'b0;
            n++;
            if (busy === 1'b1) begin
                n_vec++;
                if ({C0, A, B} !== 9'(n / (S + 1))) begin
                    n_err++;
                    $display("FAIL %s vector at cycle %0d: got %0d want %0d", name, n, {C0, A, B}, n / (S + 1));
                end
            end
        end
        n_vec++;
        if (n !== cyc_exp) begin
            n_err++;
            $display("FAIL %s run_length: got %0d cycles want %0d", name, n, cyc_exp);
        end
        got = {pass, fail_valid, fail_vec, err_cnt};
        exp = exp_q.pop_front();
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s results: got pass=%b fv=%b fvec=%0d err=%0d want pass=%b fv=%b fvec=%0d err=%0d",
                     name, got[20], got[19], got[18:10], got[9:0], exp[20], exp[19], exp[18:10], exp[9:0]);
        end
        last_exp = 9'(cyc_exp / (S + 1) - 1);
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b1 || state_dbg !== ST_DONE || {C0, A, B} !== last_exp) begin
            n_err++;
            $display("FAIL %s done_hold: busy=%b done=%b st=%0d vec=%0d want 0 1 %0d %0d",
                     name, busy, done, state_dbg, {C0, A, B}, ST_DONE, last_exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({A, B, C0, busy, done, pass, err_cnt, fail_valid, fail_vec} !== 32'd0 || state_dbg !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: outputs=%h st=%0d, want 0 st=%0d",
                     {A, B, C0, busy, done, pass, err_cnt, fail_valid, fail_vec}, state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_good_adder;
        run_check(0, "good_adder", -1, -1);
    endtask

    task automatic test_faults;
        run_check(1, "c4_stuck0", -1, -1);
        run_check(2, "f0_stuck0", -1, -1);
    endtask

    task automatic test_back_to_back;
        run_check(0, "back_to_back", -1, -1);
    endtask

    task automatic test_mid_start;
        run_check(0, "mid_start", 50, -1);
    endtask

    task automatic test_abort;
        run_check(1, "abort", -1, 100);
        run_check(0, "after_abort", -1, -1);
    endtask

    task automatic test_rst_priority;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        n_vec++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_priority: st=%0d busy=%b done=%b want st=%0d 0 0", state_dbg, busy, done, ST_IDLE);
        end
        tick();
        n_vec++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_priority_hold: st=%0d busy=%b want st=%0d 0", state_dbg, busy, ST_IDLE);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        start      = 1'b0;
        fault_mode = 2'd0;
        test_reset();
        test_good_adder();
        test_faults();
        test_back_to_back();
        test_mid_start();
        test_abort();
        test_rst_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_bist_ctrl.md
ADDER_BIST_CTRL -- requirements
Module: adder_bist_ctrl

Interface
REQ-001 The module SHALL take parameter SETTLE_CYCLES, default 2, meaning the cycles each operand set is held before its result is checked; legal range 1..15.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  one-cycle pulse that begins a test run.
REQ-006 Port A  output  4  operand A driven to the 4-bit adder under test.
REQ-007 Port B  output  4  operand B driven to the adder under test.
REQ-008 Port C0  output  1  carry-in driven to the adder under test.
REQ-009 Port F  input  4  sum returned by the adder under test.
REQ-010 Port C4  input  1  carry-out returned by the adder under test.
REQ-011 Port busy  output  1  high while a run is in progress.
REQ-012 Port done  output  1  high from the end of a run until the next start or reset.
REQ-013 Port pass  output  1  high with done when the run saw zero mismatches.
REQ-014 Port err_cnt  output  10  count of mismatching vectors in the current or last run.
REQ-015 Port fail_valid  output  1  high once any mismatch has been captured.
REQ-016 Port fail_vec  output  9  index {C0,A,B} of the first mismatching vector.

Function
REQ-017 The FSM SHALL have four states: IDLE, DRIVE, CHECK and DONE.
REQ-018 In IDLE or DONE, start SHALL clear err_cnt, fail_valid, fail_vec, done and pass, set idx to 0, and enter DRIVE on the next cycle.
REQ-019 start SHALL be ignored while busy is high (DRIVE or CHECK).
REQ-020 The outputs {C0,A,B} SHALL equal the registered 9-bit idx in DRIVE and CHECK, with idx[8]=C0, idx[7:4]=A and idx[3:0]=B.
REQ-021 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a settle counter cleared on DRIVE entry, and SHALL then go to CHECK.
REQ-022 CHECK SHALL last one cycle and SHALL compare {C4,F} with the 5-bit golden sum A+B+C0, with no truncation of the carry.
REQ-023 On a mismatch, err_cnt SHALL increment; if fail_valid is 0, fail_vec SHALL load idx and fail_valid SHALL be set.
REQ-024 After CHECK, if idx is 511 the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL return to DRIVE.
REQ-025 idx SHALL never wrap within a run.
REQ-026 A full run SHALL take exactly 512*(SETTLE_CYCLES+1) cycles from DRIVE entry to DONE entry.
REQ-027 In DONE, done SHALL be 1, pass SHALL equal (err_cnt==0), and A, B and C0 SHALL hold their last values.
REQ-028 busy SHALL be registered and high exactly in DRIVE and CHECK.
REQ-029 err_cnt SHALL be wide enough that its maximum of 512 cannot overflow.

Reset
REQ-030 rst SHALL force IDLE and zero A, B, C0, busy, done, pass, err_cnt, fail_valid, fail_vec, idx and the settle counter.
REQ-031 rst SHALL take priority over start, including when both are high in the same cycle.
REQ-032 rst asserted mid-run SHALL abort the run without asserting done.

Configuration
REQ-033 With macro ADDER_BIST_STOP_ON_FAIL_EN defined, the first mismatch in CHECK SHALL move the FSM directly to DONE with err_cnt=1 and pass=0.
REQ-034 Without ADDER_BIST_STOP_ON_FAIL_EN, the run SHALL always cover all 512 vectors.

Structure
REQ-035 A shared package adder_bist_pkg SHALL hold the state enumeration, VEC_W=9, LAST_VEC=511 and ERR_W=10.
REQ-036 The golden sum SHALL be computed in one combinational sub-module, adder_bist_golden, with inputs (A,B,C0) and a 5-bit output.

Verification
REQ-037 Correct adder, SETTLE_CYCLES=2, start pulse -> done rises 1536 cycles after DRIVE entry, pass=1, err_cnt=0, fail_valid=0.
REQ-038 Adder with C4 stuck at 0 -> err_cnt=256, fail_valid=1, fail_vec=31 (C0=0, A=1, B=15), pass=0.
REQ-039 Adder with F[0] stuck at 0 -> err_cnt=256, fail_vec=1; with ADDER_BIST_STOP_ON_FAIL_EN defined -> done after 2*(SETTLE_CYCLES+1) cycles, err_cnt=1.
REQ-040 rst asserted at idx=100, then start -> all outputs 0 the cycle after rst; new run begins at idx=0 and completes normally.
REQ-041 start pulsed at idx=50 mid-run -> ignored; run completes at the nominal cycle count.
REQ-042 Second start from DONE -> err_cnt and fail_vec cleared on DRIVE entry; results reflect only the new run.
